// File: rtl/srl_fifo_sync.sv
// Shift-register FIFO: pushes shift into index 0, pops read index COUNT-1; read data 1 clk after RE.
// No backpressure: writes at full are dropped (sticky OVF), reads at empty are dropped (sticky UDF).
module srl_fifo_sync #(
  parameter int SELWIDTH  = 5,
  parameter int WIDTH     = 8,
  parameter int AFULL_LVL = 28
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [WIDTH-1:0]    DIN,
  input  logic                RE,
  output logic [WIDTH-1:0]    DO,
  output logic                VALID,
  output logic                FULL,
  output logic                EMPTY,
  output logic                ALMOST_FULL,
  output logic [SELWIDTH:0]   COUNT,
  output logic                OVF,
  output logic                UDF
);

  localparam int DEPTH = 2 ** SELWIDTH;
  localparam logic [SELWIDTH:0]   DEPTH_C = (SELWIDTH + 1)'(DEPTH);
  localparam logic [SELWIDTH:0]   AFULL_C = (SELWIDTH + 1)'(AFULL_LVL);
  localparam logic [SELWIDTH:0]   ONE_C   = (SELWIDTH + 1)'(1);
  localparam logic [SELWIDTH-1:0] ONE_SEL = SELWIDTH'(1);

  logic [WIDTH-1:0]    chain [DEPTH];
  logic                push;
  logic                pop;
  logic [SELWIDTH-1:0] rd_idx;

  assign FULL        = (COUNT == DEPTH_C);
  assign EMPTY       = (COUNT == '0);
  assign ALMOST_FULL = (COUNT >= AFULL_C);

  assign pop  = RE & ~EMPTY;
  assign push = WE & (~FULL | RE);

  // At COUNT==DEPTH the low bits are zero, so the wrap lands on DEPTH-1.
  assign rd_idx = COUNT[SELWIDTH-1:0] - ONE_SEL;

  // Unreset storage so the chains map onto shift-register primitives.
  always_ff @(posedge CLK) begin
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        chain[i] <= chain[i-1];
      end
      chain[0] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      COUNT <= '0;
      DO    <= '0;
      VALID <= 1'b0;
      OVF   <= 1'b0;
      UDF   <= 1'b0;
    end else begin
      VALID <= pop;
      if (pop) begin
        DO <= chain[rd_idx];
      end
      case ({push, pop})
        2'b10:   COUNT <= COUNT + ONE_C;
        2'b01:   COUNT <= COUNT - ONE_C;
        default: COUNT <= COUNT;
      endcase
      if (WE & FULL & ~RE) begin
        OVF <= 1'b1;
      end
      if (RE & EMPTY) begin
        UDF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_srl_fifo_sync.sv
// Directed bench for srl_fifo_sync: vector table for basic flow, hand sequences for fill/stream/reset.
module tb_srl_fifo_sync;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WE  = 1'b0;
  logic       RE  = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic [7:0] DO;
  logic       VALID, FULL, EMPTY, ALMOST_FULL, OVF, UDF;
  logic [5:0] COUNT;

  int n_pass = 0;
  int n_total = 0;

  srl_fifo_sync #(.SELWIDTH(5), .WIDTH(8), .AFULL_LVL(28)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .DIN(DIN), .RE(RE), .DO(DO), .VALID(VALID),
    .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .COUNT(COUNT),
    .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [5:0] cnt;
    logic       vld;
    logic [7:0] dout;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl [10];
  logic [7:0] q [$];
  logic [7:0] exp_d;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    RST = r; WE = w; RE = rd; DIN = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // rst we re din | cnt vld do emp ful ovf udf
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 6'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 6'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h33, 6'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'd2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'd1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'd0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h5C, 6'd1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'd0, 1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].din);
      chk("vec.count", i, 32'(COUNT), 32'(tbl[i].cnt));
      chk("vec.valid", i, 32'(VALID), 32'(tbl[i].vld));
      chk("vec.do",    i, 32'(DO),    32'(tbl[i].dout));
      chk("vec.empty", i, 32'(EMPTY), 32'(tbl[i].emp));
      chk("vec.full",  i, 32'(FULL),  32'(tbl[i].ful));
      chk("vec.ovf",   i, 32'(OVF),   32'(tbl[i].ovf));
      chk("vec.udf",   i, 32'(UDF),   32'(tbl[i].udf));
    end

    // Fill to full, watching the almost-full threshold.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst.udf", 0, 32'(UDF), 32'd0);
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(k - 1));
      chk("fill.afull", k, 32'(ALMOST_FULL), (k >= 28) ? 32'd1 : 32'd0);
      chk("fill.count", k, 32'(COUNT), 32'(k));
    end
    chk("fill.full", 0, 32'(FULL), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("ovf.flag",  0, 32'(OVF),   32'd1);
    chk("ovf.count", 0, 32'(COUNT), 32'd32);

    // Simultaneous write/read at full.
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("fullrw.do",    0, 32'(DO),    32'h00);
    chk("fullrw.valid", 0, 32'(VALID), 32'd1);
    chk("fullrw.count", 0, 32'(COUNT), 32'd32);
    chk("fullrw.full",  0, 32'(FULL),  32'd1);
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain.do",    k, 32'(DO),    (k <= 31) ? 32'(k) : 32'hAA);
      chk("drain.valid", k, 32'(VALID), 32'd1);
    end
    chk("drain.empty", 0, 32'(EMPTY), 32'd1);
    chk("drain.count", 0, 32'(COUNT), 32'd0);

    // Steady-state streaming at occupancy 4.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + k));
      q.push_back(8'(8'hA0 + k));
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'hB0 + k));
      q.push_back(8'(8'hB0 + k));
      exp_d = q.pop_front();
      chk("stream.count", k, 32'(COUNT), 32'd4);
      chk("stream.do",    k, 32'(DO),    32'(exp_d));
      chk("stream.valid", k, 32'(VALID), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      exp_d = q.pop_front();
      chk("tail.do", k, 32'(DO), 32'(exp_d));
    end
    chk("tail.empty", 0, 32'(EMPTY), 32'd1);

    // Reset mid-operation with a write pending.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + k));
    end
    chk("pre.count", 0, 32'(COUNT), 32'd5);
    chk("pre.ovf",   0, 32'(OVF),   32'd1);
    step(1'b1, 1'b1, 1'b0, 8'hDD);
    chk("mrst.count", 0, 32'(COUNT), 32'd0);
    chk("mrst.ovf",   0, 32'(OVF),   32'd0);
    chk("mrst.do",    0, 32'(DO),    32'h00);
    chk("mrst.empty", 0, 32'(EMPTY), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post.do",    0, 32'(DO),    32'h77);
    chk("post.valid", 0, 32'(VALID), 32'd1);
    chk("post.empty", 0, 32'(EMPTY), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("post.vldlo", 0, 32'(VALID), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
